sample_recorder: RTL and testbench

Capture-side counterpart of the flash playback path. Pops 16-bit samples from the audio core's ADC FIFOs with the `read_ready`/`read_s` handshake. Packs each pair of consecutive samples into one 32-bit word and writes the words sequentially to an Avalon-MM memory slave (flash or on-chip RAM). The word layout is the one the playback path unpacks.

---
 rtl/sound_pkg.sv | 27 ++
 rtl/sample_recorder_if.sv | 27 ++
 rtl/sample_packer.sv | 50 +++++
 rtl/sample_recorder.sv | 114 +++++++++++
 tb/tb_sample_recorder.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sound_pkg.sv
// Shared audio definitions: recorder state encoding, sample/word widths and the
// pair-packing helper that the playback path unpacks from the same layout.
package sound_pkg;

  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;

  typedef enum logic [2:0] {
    REC_IDLE,
    REC_WAIT_READY,
    REC_WAIT_POP,
    REC_WRITE_MEM,
    REC_DONE
  } rec_state_t;

  // The first sample of a pair goes in the low half, the second in the high half.
  function automatic logic [WORD_W-1:0] pack_pair(input logic [SAMPLE_W-1:0] first,
                                                  input logic [SAMPLE_W-1:0] second);
    return {second, first};
  endfunction

  function automatic logic [SAMPLE_W-1:0] unpack_sample(input logic [WORD_W-1:0] word,
                                                        input logic              hi);
    return hi ? word[WORD_W-1:SAMPLE_W] : word[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/sample_recorder_if.sv
// Audio-core ADC pop handshake plus Avalon-MM write master signals used by the
// sample recorder; master = recorder side, slave = audio core / memory side.
interface sample_recorder_if
  import sound_pkg::*;
#(
  parameter int ADDR_W = 23
);
  logic                       read_ready;
  logic signed [SAMPLE_W-1:0] readdata_left;
  logic signed [SAMPLE_W-1:0] readdata_right;
  logic                       read_s;
  logic                       mem_write;
  logic [ADDR_W-1:0]          mem_address;
  logic [WORD_W-1:0]          mem_writedata;
  logic [3:0]                 mem_byteenable;
  logic                       mem_waitrequest;

  modport master (
    input  read_ready, readdata_left, readdata_right, mem_waitrequest,
    output read_s, mem_write, mem_address, mem_writedata, mem_byteenable
  );

  modport slave (
    output read_ready, readdata_left, readdata_right, mem_waitrequest,
    input  read_s, mem_write, mem_address, mem_writedata, mem_byteenable
  );
endinterface

// File: rtl/sample_packer.sv
// Sample selection and 32-bit pair assembly for the recorder. With
// SAMPLE_RECORDER_STEREO_AVG_EN defined the stored sample is the floor average of both channels.
module sample_packer
  import sound_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetb,
  input  logic                       clear,
  input  logic                       load,
  input  logic                       advance,
  input  logic signed [SAMPLE_W-1:0] left,
  input  logic signed [SAMPLE_W-1:0] right,
  output logic                       half,
  output logic [WORD_W-1:0]          word
);

  // 17-bit sum dropped by one bit is an arithmetic shift, i.e. rounding toward -inf.
  function automatic logic signed [SAMPLE_W-1:0] avg2(input logic signed [SAMPLE_W-1:0] a,
                                                      input logic signed [SAMPLE_W-1:0] b);
    logic signed [SAMPLE_W:0] sum;
    sum = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
    return sum[SAMPLE_W:1];
  endfunction

  logic signed [SAMPLE_W-1:0] sel;

`ifdef SAMPLE_RECORDER_STEREO_AVG_EN
  assign sel = avg2(left, right);
`else
  logic unused_right;
  assign unused_right = ^right;
  assign sel = left;
`endif

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      half <= 1'b0;
      word <= '0;
    end else if (clear) begin
      half <= 1'b0;
    end else begin
      if (load) begin
        if (!half) word[SAMPLE_W-1:0] <= sel;
        else       word <= pack_pair(word[SAMPLE_W-1:0], sel);
      end
      if (advance) half <= ~half;
    end
  end

endmodule

// File: rtl/sample_recorder.sv
// Records ADC samples: pops pairs from the audio core, packs them and writes them
// sequentially to an Avalon-MM slave. Optional SAMPLE_RECORDER_STEREO_AVG_EN averages channels.
module sample_recorder
  import sound_pkg::*;
#(
  parameter int ADDR_W    = 23,
  parameter int BASE_ADDR = 0,
  parameter int NUM_WORDS = 1048576
)(
  input  logic              clk,
  input  logic              resetb,
  input  logic              start,
  sample_recorder_if.master bus,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LAST_W = (ADDR_W+1)'(NUM_WORDS);

  rec_state_t        state;
  logic              read_s;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic              half;
  logic [ADDR_W:0]   wc_next;
  logic              pk_clear;
  logic              pk_load;
  logic              pk_advance;

  assign pk_clear   = (state == REC_IDLE) && start;
  assign pk_load    = (state == REC_WAIT_READY) && bus.read_ready;
  assign pk_advance = (state == REC_WAIT_POP) && !bus.read_ready;
  assign wc_next    = word_count + (ADDR_W+1)'(1);

  sample_packer u_packer (
    .clk     (clk),
    .resetb  (resetb),
    .clear   (pk_clear),
    .load    (pk_load),
    .advance (pk_advance),
    .left    (bus.readdata_left),
    .right   (bus.readdata_right),
    .half    (half),
    .word    (bus.mem_writedata)
  );

  assign bus.read_s         = read_s;
  assign bus.mem_write      = mem_write;
  assign bus.mem_address    = mem_address;
  assign bus.mem_byteenable = 4'b1111;

  // half is read before the packer toggles it on the same edge.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state       <= REC_IDLE;
      read_s      <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      word_count  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        REC_IDLE: begin
          if (start) begin
            word_count  <= '0;
            mem_address <= BASE_A;
            busy        <= 1'b1;
            state       <= REC_WAIT_READY;
          end
        end
        REC_WAIT_READY: begin
          if (bus.read_ready) begin
            read_s <= 1'b1;
            state  <= REC_WAIT_POP;
          end
        end
        REC_WAIT_POP: begin
          if (!bus.read_ready) begin
            read_s <= 1'b0;
            if (half) begin
              mem_write <= 1'b1;
              state     <= REC_WRITE_MEM;
            end else begin
              state <= REC_WAIT_READY;
            end
          end
        end
        REC_WRITE_MEM: begin
          if (!bus.mem_waitrequest) begin
            mem_write   <= 1'b0;
            mem_address <= mem_address + ADDR_W'(1);
            word_count  <= wc_next;
            if (wc_next == LAST_W) begin
              done  <= 1'b1;
              state <= REC_DONE;
            end else begin
              state <= REC_WAIT_READY;
            end
          end
        end
        REC_DONE: begin
          busy  <= 1'b0;
          state <= REC_IDLE;
        end
        default: state <= REC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_recorder.sv
// Scoreboard bench for sample_recorder: randomized audio source and memory stall
// driver, reference word stream computed from the sample list, decoupled write monitor.
module tb_sample_recorder;

  localparam int AW   = 8;
  localparam int BASE = 16;
  localparam int NW   = 2;

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [AW:0]   word_count;

  sample_recorder_if #(.ADDR_W(AW)) bus();

  sample_recorder #(.ADDR_W(AW), .BASE_ADDR(BASE), .NUM_WORDS(NW)) dut (
    .clk        (clk),
    .resetb     (resetb),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  logic [15:0]   src_l[$];
  logic [15:0]   src_r[$];
  logic [15:0]   pend[$];
  int            widx;
  int            stall_q[$];
  int            acc_count;

  int fixed_stall = 0;
  bit rand_wr = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: what the recorder is supposed to store for one popped sample.
  function automatic logic [15:0] model_sample(input logic [15:0] l, input logic [15:0] r);
`ifdef SAMPLE_RECORDER_STEREO_AVG_EN
    int s;
    s = int'($signed(l)) + int'($signed(r));
    s = (s < 0 && (s % 2) != 0) ? (s - 1) / 2 : s / 2;
    return 16'(s);
`else
    return l;
`endif
  endfunction

  task automatic model_push(input logic [15:0] l, input logic [15:0] r);
    logic [15:0] first;
    pend.push_back(model_sample(l, r));
    if (pend.size() == 2) begin
      first = pend.pop_front();
      exp_data.push_back(32'(pend.pop_front()) * 32'd65536 + 32'(first));
      exp_addr.push_back(AW'(BASE + widx));
      widx++;
    end
  endtask

  task automatic model_reset();
    pend.delete();
    exp_addr.delete();
    exp_data.delete();
    stall_q.delete();
    widx = 0;
    acc_count = 0;
  endtask

  // Memory side: stall each new write for a chosen number of cycles.
  initial begin
    int  left_cnt;
    bit  armed;
    armed = 1'b1;
    left_cnt = 0;
    bus.mem_waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!bus.mem_write) begin
        armed = 1'b1;
        bus.mem_waitrequest = rand_wr ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        if (armed) begin
          left_cnt = rand_wr ? int'($urandom_range(0, 3)) : fixed_stall;
          armed = 1'b0;
        end
        if (left_cnt > 0) begin
          bus.mem_waitrequest = 1'b1;
          left_cnt--;
        end else begin
          bus.mem_waitrequest = 1'b0;
        end
      end
    end
  end

  // Monitor: compares every accepted write against the scoreboard.
  initial begin
    bit            held, cnt_pend, prev_acc, acc;
    logic [AW-1:0] h_addr;
    logic [31:0]   h_data;
    int            stall_cnt;
    held = 0; cnt_pend = 0; prev_acc = 0; stall_cnt = 0;
    h_addr = '0; h_data = '0;
    forever begin
      @(negedge clk);
      acc = 1'b0;
      if (!resetb) begin
        held = 0; cnt_pend = 0; prev_acc = 0; stall_cnt = 0;
      end else begin
        if (cnt_pend) begin
          chk("word_count_step", 64'(word_count), 64'(acc_count));
          cnt_pend = 0;
        end
        if (bus.mem_write) begin
          if (held) begin
            chk("stall_addr_stable", 64'(bus.mem_address), 64'(h_addr));
            chk("stall_data_stable", 64'(bus.mem_writedata), 64'(h_data));
          end
          if (bus.mem_waitrequest) begin
            held = 1; stall_cnt++;
            h_addr = bus.mem_address; h_data = bus.mem_writedata;
          end else begin
            acc = 1'b1;
            checks++;
            if (exp_data.size() == 0) begin
              errors++;
              $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected",
                       bus.mem_address, bus.mem_writedata);
            end else begin
              chk("write_addr", 64'(bus.mem_address), 64'(exp_addr.pop_front()));
              chk("write_data", 64'(bus.mem_writedata), 64'(exp_data.pop_front()));
            end
            chk("byteenable", 64'(bus.mem_byteenable), 64'hF);
            acc_count++;
            stall_q.push_back(stall_cnt);
            stall_cnt = 0; held = 0; cnt_pend = 1;
          end
        end else begin
          held = 0;
        end
        if (done) chk("done_after_accept", 64'(prev_acc), 64'd1);
        prev_acc = acc;
      end
    end
  end

  bit abort;

  task automatic send_samples(input int n, input int hold_mode, input bit start_in_pop);
    int cnt, hold, gap;
    logic [15:0] l, r;
    for (int i = 0; i < n && !abort; i++) begin
      l = src_l.pop_front();
      r = src_r.pop_front();
      gap = int'($urandom_range(0, 3));
      repeat (gap) step();
      bus.readdata_left = l;
      bus.readdata_right = r;
      bus.read_ready = 1'b1;
      model_push(l, r);
      cnt = 0;
      while (!bus.read_s && cnt < 200) begin
        step();
        cnt++;
      end
      if (!bus.read_s) begin
        checks++; errors++;
        $display("FAIL read_s_timeout: got read_s 0 expected 1 within 200 cycles");
        abort = 1'b1;
        bus.read_ready = 1'b0;
        return;
      end
      if (start_in_pop && i == 0) begin
        start = 1'b1;
        step();
        start = 1'b0;
        chk("read_s_hold_start", 64'(bus.read_s), 64'd1);
      end
      hold = (hold_mode < 0) ? int'($urandom_range(0, 2)) : hold_mode;
      for (int h = 0; h < hold; h++) begin
        step();
        chk("read_s_hold", 64'(bus.read_s), 64'd1);
      end
      bus.read_ready = 1'b0;
      bus.readdata_left = 16'($urandom);
      bus.readdata_right = 16'($urandom);
      step();
      chk("read_s_fall", 64'(bus.read_s), 64'd0);
    end
  endtask

  task automatic wait_done();
    int cnt;
    cnt = 0;
    while (!done && cnt < 2000) begin
      step();
      cnt++;
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic run_rec(input int hold_mode, input bit start_in_pop);
    model_reset();
    abort = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    send_samples(2 * NW, hold_mode, start_in_pop);
    wait_done();
    chk("word_count_final", 64'(word_count), 64'(NW));
    step();
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("scoreboard_empty", 64'(exp_data.size()), 64'd0);
    chk("accepted_writes", 64'(acc_count), 64'(NW));
  endtask

  task automatic push_src(input logic [15:0] l, input logic [15:0] r);
    src_l.push_back(l);
    src_r.push_back(r);
  endtask

  initial begin
    bus.read_ready = 1'b0;
    bus.readdata_left = '0;
    bus.readdata_right = '0;
    model_reset();
    repeat (3) step();
    chk("rst_read_s", 64'(bus.read_s), 64'd0);
    chk("rst_mem_write", 64'(bus.mem_write), 64'd0);
    chk("rst_address", 64'(bus.mem_address), 64'd0);
    chk("rst_writedata", 64'(bus.mem_writedata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_word_count", 64'(word_count), 64'd0);
    resetb = 1'b1;
    step();

    // Basic packing with left = right so both builds store the same halves.
    push_src(16'h0001, 16'h0001); push_src(16'h0002, 16'h0002);
    push_src(16'h0003, 16'h0003); push_src(16'h0004, 16'h0004);
    run_rec(0, 1'b0);

    // Five-cycle stall on every word.
    fixed_stall = 5;
    push_src(16'h1111, 16'h2222); push_src(16'h3333, 16'h4444);
    push_src(16'h5555, 16'h6666); push_src(16'h7777, 16'h8888);
    run_rec(0, 1'b0);
    chk("stall_words", 64'(stall_q.size()), 64'd2);
    if (stall_q.size() > 0) chk("stall_len_word0", 64'(stall_q[0]), 64'd5);
    fixed_stall = 0;

    // Channel extremes, start pulsed while popping, read_ready held 3 cycles.
    push_src(16'h7FFF, 16'h7FFF); push_src(16'h8000, 16'hFFFF);
    push_src(16'h8000, 16'h8000); push_src(16'hFFFF, 16'h0001);
    run_rec(3, 1'b1);

    // Reset while a write is stalled.
    model_reset();
    abort = 1'b0;
    fixed_stall = 50;
    start = 1'b1;
    step();
    start = 1'b0;
    push_src(16'hAAAA, 16'h5555); push_src(16'hBBBB, 16'h4444);
    send_samples(2, 0, 1'b0);
    chk("stall_write_pending", 64'(bus.mem_write), 64'd1);
    step();
    step();
    resetb = 1'b0;
    #1;
    chk("midwrite_rst_mem_write", 64'(bus.mem_write), 64'd0);
    chk("midwrite_rst_busy", 64'(busy), 64'd0);
    chk("midwrite_rst_word_count", 64'(word_count), 64'd0);
    model_reset();
    step();
    resetb = 1'b1;
    fixed_stall = 0;
    step();
    push_src(16'h0102, 16'h0000); push_src(16'h0304, 16'h0000);
    push_src(16'h0506, 16'h0000); push_src(16'h0708, 16'h0000);
    run_rec(1, 1'b0);

    // Randomized recordings with random stalls, gaps and hold lengths.
    rand_wr = 1'b1;
    for (int k = 0; k < 12; k++) begin
      for (int s = 0; s < 2 * NW; s++) push_src(16'($urandom), 16'($urandom));
      run_rec(-1, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
